// File: rtl/dmem_pkg.sv
// dmem_pkg: shared states, owner encoding and default widths for the data-RAM arbiter.
package dmem_pkg;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_STARVE_LIMIT = 8;
  typedef enum logic [1:0] {PROC, IO_GRANT, FORCE} state_t;
  typedef enum logic {OWN_PROC, OWN_IO} owner_t;
endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// starve_counter: saturating count of consecutive denied secondary cycles.
// at_limit flags that the current denial brings the count to LIMIT.
module starve_counter #(
  parameter int LIMIT = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = clr ? '0 : (inc && cnt_q != W'(LIMIT)) ? cnt_q + 1'b1 : cnt_q;
  end
  assign at_limit = inc && cnt_q >= W'(LIMIT - 1);
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the processor and a secondary requester.
// Define DMEM_ARB_STARVE_GUARD_EN to add the forced-grant starvation guard.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              proc_req,
  input  logic              proc_wren,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [DATA_W-1:0] proc_data,
  output logic [DATA_W-1:0] proc_q,
  output logic              proc_stall,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_gnt,
  output logic              io_rvalid,
  output logic [DATA_W-1:0] io_rdata,
  output logic              ram_wEn,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dataIn,
  input  logic [DATA_W-1:0] ram_dataOut
);
  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end
  state_t state_q, state_d;
  owner_t owner_q, owner_d;
  logic rd_q, rd_d;
  logic force_st, io_own, proc_own, at_limit;
  assign force_st = state_q == FORCE;
`ifdef DMEM_ARB_STARVE_GUARD_EN
  starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clock   (clock),
    .reset   (reset),
    .clr     (io_gnt || !io_req),
    .inc     (io_req && !io_gnt),
    .at_limit(at_limit)
  );
  assign proc_stall = force_st;
`else
  assign at_limit = 1'b0;
  assign proc_stall = 1'b0;
`endif
  always_comb begin
    io_own = reset && (force_st ? io_req : !proc_req && io_req);
    proc_own = reset && !force_st && proc_req;
    state_d = force_st ? PROC : io_own ? IO_GRANT : (proc_req && at_limit) ? FORCE : PROC;
    owner_d = io_own ? OWN_IO : OWN_PROC;
    rd_d = io_own ? !io_we : proc_own && !proc_wren;
  end
  assign io_gnt = io_own;
  assign ram_addr = io_own ? io_addr : proc_addr;
  assign ram_dataIn = io_own ? io_wdata : proc_data;
  assign ram_wEn = io_own ? io_we : proc_own && proc_wren;
  assign io_rvalid = owner_q == OWN_IO && rd_q;
  assign io_rdata = ram_dataOut;
  assign proc_q = ram_dataOut;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= PROC;
      owner_q <= OWN_PROC;
      rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rd_q <= rd_d;
    end
  end
endmodule
